// File: rtl/distortion_processor.sv
// Distortion stage: gain/overdrive, fuzz and hard-clip on a 16-bit signed sample stream, with click-suppressing mute on mode change.
// Latency: fixed 3 cycles from in_valid to out_valid, one sample per cycle.
// Backpressure: none; every accepted sample produces exactly one output strobe.
module distortion_processor #(
  parameter int unsigned MUTE_SAMPLES = 4,
  parameter int unsigned CLIP_HOLD    = 2400000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic signed [15:0] in_sample,
  input  logic               in_valid,
  input  logic signed [15:0] gain,
  input  logic signed [31:0] threshold,
  input  logic        [1:0]  mode,
  output logic signed [15:0] out_sample,
  output logic               out_valid,
  output logic               clip_led,
  output logic               muted
);

  localparam logic [31:0] MUTE_N = 32'(MUTE_SAMPLES);
  localparam logic [31:0] CLIP_N = 32'(CLIP_HOLD);

  typedef enum logic {ST_RUN = 1'b0, ST_MUTE = 1'b1} state_t;

  // mute state machine
  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_mute_cnt;
  logic [31:0] w_cnt_nxt;
  logic [1:0]  r_last_mode;
  logic        w_mute_now;

  // conditioned settings and sample at the input
  logic [5:0]         w_gain_eff;
  logic [14:0]        w_lim_eff;
  logic signed [15:0] w_sample_in;

  // stage 1
  logic               r1_vld;
  logic signed [15:0] r1_sample;
  logic [5:0]         r1_gain;
  logic [14:0]        r1_lim;
  logic [1:0]         r1_mode;
  logic               r1_mute;

  // stage 2 arithmetic
  logic signed [31:0] w_s32;
  logic signed [31:0] w_g32;
  logic signed [31:0] w_l32;
  logic signed [31:0] w_prod;
  logic signed [31:0] w_pre;
  logic signed [31:0] w_hi;
  logic               w_sat_en;
  logic signed [15:0] w_res;
  logic               w_clip;

  // stage 2 registers
  logic               r2_vld;
  logic signed [15:0] r2_sample;
  logic               r2_clip;

  // clip LED hold
  logic [31:0] r_clip_cnt;

  // Clamp gain to 1..50, limit to 0..32767, and fold -32768 onto -32767 so every mode stays symmetric.
  always_comb begin
    w_gain_eff = gain[5:0];
    if (gain < 16'sd1) begin
      w_gain_eff = 6'd1;
    end else if (gain > 16'sd50) begin
      w_gain_eff = 6'd50;
    end
    w_lim_eff = threshold[14:0];
    if (threshold < 32'sd0) begin
      w_lim_eff = 15'd0;
    end else if (threshold > 32'sd32767) begin
      w_lim_eff = 15'h7FFF;
    end
    w_sample_in = (in_sample == 16'sh8000) ? 16'sh8001 : in_sample;
  end

  // Mute decision for the sample being accepted; the triggering sample counts as the first muted one.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_mute_cnt;
    w_mute_now  = 1'b0;
    if (in_valid) begin
      if ((mode != r_last_mode) && (MUTE_N != 32'd0)) begin
        w_mute_now  = 1'b1;
        w_cnt_nxt   = MUTE_N - 32'd1;
        w_state_nxt = (MUTE_N == 32'd1) ? ST_RUN : ST_MUTE;
      end else if (r_state == ST_MUTE) begin
        w_mute_now = 1'b1;
        w_cnt_nxt  = r_mute_cnt - 32'd1;
        if (r_mute_cnt == 32'd1) begin
          w_state_nxt = ST_RUN;
        end
      end
    end
  end

  // Mute state, remaining-sample count and last seen mode.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_RUN;
      r_mute_cnt  <= 32'd0;
      r_last_mode <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_mute_cnt <= w_cnt_nxt;
      if (in_valid) begin
        r_last_mode <= mode;
      end
    end
  end

  // Stage 1: capture sample, conditioned settings and mute decision together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r1_vld    <= 1'b0;
      r1_sample <= 16'sd0;
      r1_gain   <= 6'd1;
      r1_lim    <= 15'd0;
      r1_mode   <= 2'd0;
      r1_mute   <= 1'b0;
    end else begin
      r1_vld <= in_valid;
      if (in_valid) begin
        r1_sample <= w_sample_in;
        r1_gain   <= w_gain_eff;
        r1_lim    <= w_lim_eff;
        r1_mode   <= mode;
        r1_mute   <= w_mute_now;
      end
    end
  end

  assign w_s32  = {{16{r1_sample[15]}}, r1_sample};
  assign w_g32  = {26'd0, r1_gain};
  assign w_l32  = {17'd0, r1_lim};
  assign w_prod = w_s32 * w_g32;

  // Pick the pre-saturation value and bound per mode, then saturate symmetrically and flag any change.
  always_comb begin
    w_pre    = w_s32;
    w_hi     = 32'sd32767;
    w_sat_en = 1'b1;
    case (r1_mode)
      2'd0:    w_sat_en = 1'b0;
      2'd1:    w_pre = w_prod;
      2'd2: begin
        w_pre = w_prod;
        w_hi  = w_l32;
      end
      default: w_hi = w_l32;
    endcase
    w_res  = w_pre[15:0];
    w_clip = 1'b0;
    if (w_sat_en) begin
      if (w_pre > w_hi) begin
        w_res  = w_hi[15:0];
        w_clip = 1'b1;
      end else if (w_pre < -w_hi) begin
        w_res  = w_hi[15:0] * -16'sd1;
        w_clip = 1'b1;
      end
    end
  end

  // Stage 2: register the result, zeroed when muted; a muted sample never counts as clipped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r2_vld    <= 1'b0;
      r2_sample <= 16'sd0;
      r2_clip   <= 1'b0;
    end else begin
      r2_vld <= r1_vld;
      if (r1_vld) begin
        r2_sample <= r1_mute ? 16'sd0 : w_res;
        r2_clip   <= w_clip & ~r1_mute;
      end
    end
  end

  // Stage 3: output register, holds the last sample between strobes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid  <= 1'b0;
      out_sample <= 16'sd0;
    end else begin
      out_valid <= r2_vld;
      if (r2_vld) begin
        out_sample <= r2_sample;
      end
    end
  end

  // Clip hold: reload on every clipped result leaving stage 2, otherwise count down to zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_clip_cnt <= 32'd0;
    end else if (r2_vld && r2_clip) begin
      r_clip_cnt <= CLIP_N;
    end else if (r_clip_cnt != 32'd0) begin
      r_clip_cnt <= r_clip_cnt - 32'd1;
    end
  end

  assign clip_led = (r_clip_cnt != 32'd0);
  assign muted    = (r_state == ST_MUTE);

endmodule

// File: tb/tb_distortion_processor.sv
// Bench for distortion_processor: two instances (no mute, 4-sample mute) share stimulus.
// Directed test-plan steps, then randomized traffic against a sample-level reference model.
// Reset mid-stream discards in-flight samples in the model as well.
module tb_distortion_processor;

  localparam int CH = 10;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic signed [15:0] in_sample = 16'sd0;
  logic               in_valid = 1'b0;
  logic signed [15:0] gain = 16'sd1;
  logic signed [31:0] threshold = 32'sd0;
  logic        [1:0]  mode = 2'd0;

  logic signed [15:0] o0_sample, o4_sample;
  logic               o0_vld, o4_vld, o0_clip, o4_clip, o0_muted, o4_muted;

  distortion_processor #(.MUTE_SAMPLES(0), .CLIP_HOLD(CH)) u_dut0 (
    .CLK(CLK), .RST(RST), .in_sample(in_sample), .in_valid(in_valid), .gain(gain),
    .threshold(threshold), .mode(mode), .out_sample(o0_sample), .out_valid(o0_vld),
    .clip_led(o0_clip), .muted(o0_muted)
  );

  distortion_processor #(.MUTE_SAMPLES(4), .CLIP_HOLD(CH)) u_dut4 (
    .CLK(CLK), .RST(RST), .in_sample(in_sample), .in_valid(in_valid), .gain(gain),
    .threshold(threshold), .mode(mode), .out_sample(o4_sample), .out_valid(o4_vld),
    .clip_led(o4_clip), .muted(o4_muted)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int due;
    int val0;
    int val1;
    bit cl0;
    bit cl1;
  } exp_t;

  int   mute_n [2] = '{0, 4};
  int   zeros_to_go [2];
  int   last_mode [2];
  int   hold [2];
  int   last_out [2];
  exp_t q [$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   zero4 = 0;
  int   n4000 = 0;
  int   clipcnt = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int clampv(input int v, input int lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  // Sample-level reference: result and whether saturation/clamping altered it.
  function automatic void ref_calc(input int s_in, input int g_in, input int t_in, input int m,
                                   output int r, output bit c);
    int s, g, l, pre;
    s = (s_in == -32768) ? -32767 : s_in;
    g = (g_in < 1) ? 1 : ((g_in > 50) ? 50 : g_in);
    l = (t_in < 0) ? 0 : ((t_in > 32767) ? 32767 : t_in);
    case (m)
      0: begin pre = s;     r = s; end
      1: begin pre = s * g; r = clampv(pre, 32767); end
      2: begin pre = s * g; r = clampv(pre, l); end
      default: begin pre = s; r = clampv(pre, l); end
    endcase
    c = (r != pre);
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 2; i++) begin
      zeros_to_go[i] = 0;
      last_mode[i]   = 0;
      hold[i]        = 0;
      last_out[i]    = 0;
    end
  endtask

  task automatic accept(input int s, input int g, input int t, input int m);
    int r;
    bit c;
    int v [2];
    bit cl [2];
    exp_t e;
    ref_calc(s, g, t, m, r, c);
    for (int i = 0; i < 2; i++) begin
      bit mt;
      if (m != last_mode[i] && mute_n[i] > 0) zeros_to_go[i] = mute_n[i];
      mt = (zeros_to_go[i] > 0);
      if (mt) zeros_to_go[i]--;
      last_mode[i] = m;
      v[i]  = mt ? 0 : r;
      cl[i] = c && !mt;
    end
    e.due = cyc + 3;
    e.val0 = v[0]; e.val1 = v[1]; e.cl0 = cl[0]; e.cl1 = cl[1];
    q.push_back(e);
  endtask

  task automatic check_outputs();
    bit   have;
    exp_t e;
    bit   cl [2];
    have = (q.size() > 0) && (q[0].due == cyc);
    cl[0] = 1'b0;
    cl[1] = 1'b0;
    if (have) begin
      e = q.pop_front();
      last_out[0] = e.val0;
      last_out[1] = e.val1;
      cl[0] = e.cl0;
      cl[1] = e.cl1;
    end
    for (int i = 0; i < 2; i++) begin
      if (cl[i]) hold[i] = CH;
      else if (hold[i] > 0) hold[i]--;
    end
    chk("vld0", o0_vld, have);
    chk("smp0", o0_sample, last_out[0]);
    chk("clip0", o0_clip, hold[0] != 0);
    chk("muted0", o0_muted, zeros_to_go[0] > 0);
    chk("vld4", o4_vld, have);
    chk("smp4", o4_sample, last_out[1]);
    chk("clip4", o4_clip, hold[1] != 0);
    chk("muted4", o4_muted, zeros_to_go[1] > 0);
  endtask

  task automatic step_clock();
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    check_outputs();
    if (o4_vld && o4_sample == 16'sd0) zero4++;
    if (o4_vld && o4_sample == 16'sd4000) n4000++;
    if (o0_clip) clipcnt++;
  endtask

  task automatic tick(input bit v, input int s, input int g, input int t, input int m);
    in_valid  = v;
    in_sample = 16'(s);
    gain      = 16'(g);
    threshold = t;
    mode      = 2'(m);
    if (v && !RST) accept(s, g, t, m);
    step_clock();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0;
      step_clock();
    end
  endtask

  initial begin
    model_reset();
    @(negedge CLK);
    idle(2);
    RST = 1'b0;
    idle(1);

    // bypass folds -32768
    tick(1, -32768, 1, 0, 0); idle(2);
    chk("bypass_min", o0_sample, -32767);
    chk("bypass_noclip", o0_clip, 0);

    // overdrive gain 4
    tick(1, 1000, 4, 0, 1); idle(2);
    chk("od_4000", o0_sample, 4000);
    chk("od_noclip", o0_clip, 0);
    clipcnt = 0;
    tick(1, 10000, 4, 0, 1); idle(14);
    chk("od_sat", o0_sample, 32767);
    chk("clip_cycles", clipcnt, CH);

    // hard clip
    tick(1, -20000, 1, 16000, 3);
    tick(1, 12000, 1, 16000, 3);
    idle(1); chk("hc_neg", o0_sample, -16000);
    idle(1); chk("hc_pos", o0_sample, 12000);
    tick(1, 30000, 1, -5, 3); idle(2);
    chk("hc_negthr", o0_sample, 0);

    // fuzz
    tick(1, 9000, 2, 16000, 2); idle(2);
    chk("fuzz_clamp", o0_sample, 16000);
    tick(1, 9000, 0, 16000, 2); idle(2);
    chk("fuzz_gain0", o0_sample, 9000);

    // mute on 0 -> 1
    for (int i = 0; i < 5; i++) tick(1, 1000, 4, 16000, 0);
    idle(3);
    zero4 = 0; n4000 = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1, 1000, 4, 16000, 1);
      if (i == 0) chk("mute_on", o4_muted, 1);
      if (i == 3) chk("mute_off", o4_muted, 0);
    end
    idle(3);
    chk("mute_zeros", zero4, 4);
    chk("mute_4000", n4000, 4);

    // change again while muted
    for (int i = 0; i < 5; i++) tick(1, 1000, 4, 16000, 0);
    idle(3);
    zero4 = 0;
    tick(1, 1000, 4, 16000, 1);
    tick(1, 1000, 4, 16000, 3);
    for (int i = 0; i < 6; i++) tick(1, 1000, 4, 16000, 3);
    idle(3);
    chk("remute_zeros", zero4, 5);

    // randomized traffic
    begin
      int m;
      m = 0;
      for (int n = 0; n < 1500; n++) begin
        int s, g, t, sel;
        bit v;
        v = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) m = int'($urandom_range(0, 3));
        s = int'($urandom_range(0, 65535)) - 32768;
        if (s == -32768) s = 0;
        g = int'($urandom_range(0, 70)) - 10;
        sel = int'($urandom_range(0, 3));
        case (sel)
          0: t = -int'($urandom_range(1, 1000));
          1: t = int'($urandom_range(0, 32767));
          2: t = 32767 + int'($urandom_range(1, 100000));
          default: t = int'($urandom_range(0, 4000));
        endcase
        tick(v, s, g, t, m);
      end
      idle(3);
    end

    // reset with two samples in flight
    for (int i = 0; i < 8; i++) tick(1, 100 * (i + 1), 1, 0, 0);
    RST = 1'b1;
    in_valid = 1'b0;
    #1;
    model_reset();
    chk("rst_smp0", o0_sample, 0);
    chk("rst_vld0", o0_vld, 0);
    chk("rst_clip0", o0_clip, 0);
    chk("rst_mute0", o0_muted, 0);
    chk("rst_smp4", o4_sample, 0);
    chk("rst_vld4", o4_vld, 0);
    chk("rst_clip4", o4_clip, 0);
    chk("rst_mute4", o4_muted, 0);
    idle(2);
    RST = 1'b0;
    tick(1, 1234, 3, 20000, 2);
    chk("post_rst_mute", o4_muted, 1);
    idle(1);
    chk("post_rst_early", o0_vld, 0);
    idle(1);
    chk("post_rst_vld", o0_vld, 1);
    chk("post_rst_smp", o0_sample, 3702);
    chk("post_rst_smp4", o4_sample, 0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
